// File: rtl/hq_a1_calc.sv
// Hq*A1 generator for the SOML decoder: one result row per cycle from built-in Hq and A1
// constants, using adds/subtracts only. All outputs are registered; ready is sticky.
module hq_a1_calc #(
    parameter int unsigned DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic [4*DW-1:0] outcol0_r,
    output logic [4*DW-1:0] outcol0_i,
    output logic [4*DW-1:0] outcol1_r,
    output logic [4*DW-1:0] outcol1_i,
    output logic            ready
);

    // Q8.8 unit; Hq imaginary entries step in half units
    localparam int Scale     = 1 << (DW / 2);
    localparam int HalfScale = Scale / 2;

    localparam logic signed [DW:0] MaxV = (DW+1)'((2 ** (DW - 1)) - 1);
    localparam logic signed [DW:0] MinV = (DW+1)'(-(2 ** (DW - 1)));

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e     state_q;
    logic [1:0] row_q;

    // Hr[i][k] = (4i+k+1) * 1.0
    function automatic logic signed [DW:0] h_re(input logic [1:0] i, input logic [1:0] k);
        return (DW+1)'((4 * int'(i) + int'(k) + 1) * Scale);
    endfunction

    // Hi[i][k] = (k-i) * 0.5
    function automatic logic signed [DW:0] h_im(input logic [1:0] i, input logic [1:0] k);
        return (DW+1)'((int'(k) - int'(i)) * HalfScale);
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [DW:0] v);
        if (v > MaxV) begin
            return MaxV[DW-1:0];
        end else if (v < MinV) begin
            return MinV[DW-1:0];
        end
        return v[DW-1:0];
    endfunction

    logic signed [DW:0] sum0_r, sum0_i, sum1_r, sum1_i;
    logic [DW-1:0]      res0_r, res0_i, res1_r, res1_i;

    // A1 col0 = [1,0,0,j]: picks H[:,0] + j*H[:,3]; col1 = [0,1,j,0]: H[:,1] + j*H[:,2]
    always_comb begin
        sum0_r = h_re(row_q, 2'd0) - h_im(row_q, 2'd3);
        sum0_i = h_im(row_q, 2'd0) + h_re(row_q, 2'd3);
        sum1_r = h_re(row_q, 2'd1) - h_im(row_q, 2'd2);
        sum1_i = h_im(row_q, 2'd1) + h_re(row_q, 2'd2);
        res0_r = sat(sum0_r);
        res0_i = sat(sum0_i);
        res1_r = sat(sum1_r);
        res1_i = sat(sum1_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            row_q     <= 2'd0;
            outcol0_r <= '0;
            outcol0_i <= '0;
            outcol1_r <= '0;
            outcol1_i <= '0;
            ready     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StCalc;
                    row_q   <= 2'd0;
                end
                StCalc: begin
                    for (int i = 0; i < 4; i++) begin
                        if (row_q == 2'(i)) begin
                            outcol0_r[i*DW +: DW] <= res0_r;
                            outcol0_i[i*DW +: DW] <= res0_i;
                            outcol1_r[i*DW +: DW] <= res1_r;
                            outcol1_i[i*DW +: DW] <= res1_i;
                        end
                    end
                    row_q <= row_q + 2'd1;
                    if (row_q == 2'd3) begin
                        state_q <= StDone;
                        ready   <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hq_a1_calc.sv
// Scoreboard bench for hq_a1_calc: random reset patterns, expected snapshots from a
// matrix-level reference model, compared by an independent monitor every cycle.
module tb_hq_a1_calc;

    typedef struct packed {
        logic [63:0] c0r;
        logic [63:0] c0i;
        logic [63:0] c1r;
        logic [63:0] c1i;
        logic        rdy;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] outcol0_r, outcol0_i, outcol1_r, outcol1_i;
    logic        ready;

    int    vectors = 0;
    int    miscompares = 0;
    int    n_low = 0;
    snap_t expq[$];

    always #5 clk = ~clk;

    hq_a1_calc #(.DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .outcol0_r (outcol0_r),
        .outcol0_i (outcol0_i),
        .outcol1_r (outcol1_r),
        .outcol1_i (outcol1_i),
        .ready     (ready)
    );

    function automatic int hr(int i, int k);
        return (4 * i + k + 1) * 256;
    endfunction

    function automatic int hi(int i, int k);
        return (k - i) * 128;
    endfunction

    function automatic logic [15:0] sat16(int v);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    // Complex product (Hr + jHi) * A1 column, entry by entry
    function automatic logic [15:0] elem(int col, bit imag, int i);
        int re = 0;
        int im = 0;
        // A1 col0 has 1 at row 0 and j at row 3; col1 has 1 at row 1 and j at row 2
        int k_one = (col == 0) ? 0 : 1;
        int k_j   = (col == 0) ? 3 : 2;
        re = hr(i, k_one) - hi(i, k_j);
        im = hi(i, k_one) + hr(i, k_j);
        return imag ? sat16(im) : sat16(re);
    endfunction

    // n = consecutive rst-low edges since the last reset edge
    function automatic snap_t model(int n);
        snap_t s = '0;
        for (int i = 0; i < 4; i++) begin
            if (n >= i + 2) begin
                s.c0r[16*i +: 16] = elem(0, 1'b0, i);
                s.c0i[16*i +: 16] = elem(0, 1'b1, i);
                s.c1r[16*i +: 16] = elem(1, 1'b0, i);
                s.c1i[16*i +: 16] = elem(1, 1'b1, i);
            end
        end
        s.rdy = (n >= 5);
        return s;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(bit r);
        @(negedge clk);
        rst = r;
        @(posedge clk);
        if (r) n_low = 0;
        else if (n_low < 10000) n_low++;
        expq.push_back(model(n_low));
    endtask

    always @(negedge clk) begin
        snap_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("outcol0_r", outcol0_r, e.c0r);
            chk("outcol0_i", outcol0_i, e.c0i);
            chk("outcol1_r", outcol1_r, e.c1r);
            chk("outcol1_i", outcol1_i, e.c1i);
            chk("ready", {63'd0, ready}, {63'd0, e.rdy});
            if (e.rdy && ready) begin
                chk("final_col0_r", outcol0_r, 64'h0D00_0880_0400_FF80);
                chk("final_col0_i", outcol0_i, 64'h0E80_0B00_0780_0400);
                chk("final_col1_r", outcol1_r, 64'h0E80_0A00_0580_0100);
                chk("final_col1_i", outcol1_i, 64'h0E00_0A80_0700_0380);
            end
        end
    end

    initial begin
        // Reset hold, then full run with a long hold in DONE
        repeat (4) cycle(1'b1);
        repeat (205) cycle(1'b0);
        // Reset in the middle of CALC, then a clean restart
        repeat (4) cycle(1'b0);
        repeat (2) cycle(1'b1);
        repeat (8) cycle(1'b0);
        for (int ep = 0; ep < 30; ep++) begin
            repeat ($urandom_range(1, 3)) cycle(1'b1);
            repeat ($urandom_range(1, 12)) cycle(1'b0);
        end
        cycle(1'b1);
        repeat (3) @(negedge clk);
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
